// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared raster definitions for the oscilloscope display pipeline.
//   - 1280x1024@60 timing constants (per axis: visible / front / sync / back)
//   - derived line and frame totals
//   - the 12-bit coordinate type consumed by every overlay/condition block
//   - the per-axis scan phase and its pure decode from a coordinate value
// -----------------------------------------------------------------------------
package vga_pkg;

  // Coordinate and frame-counter widths
  localparam int unsigned COORD_W     = 32'd12;
  localparam int unsigned FRAME_CNT_W = 32'd16;

  typedef logic [COORD_W-1:0]     coord_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

  localparam coord_t     COORD_ZERO = 12'd0;
  localparam coord_t     COORD_ONE  = 12'd1;
  localparam frame_cnt_t FRAME_ZERO = 16'd0;
  localparam frame_cnt_t FRAME_ONE  = 16'd1;

  // Coordinates must fit the 12-bit counters
  localparam int unsigned COORD_RANGE = 32'd4096;

  // 1280x1024@60 horizontal timing (pixels)
  localparam int unsigned DEF_H_VISIBLE = 32'd1280;
  localparam int unsigned DEF_H_FRONT   = 32'd48;
  localparam int unsigned DEF_H_SYNC    = 32'd112;
  localparam int unsigned DEF_H_BACK    = 32'd248;

  // 1280x1024@60 vertical timing (lines)
  localparam int unsigned DEF_V_VISIBLE = 32'd1024;
  localparam int unsigned DEF_V_FRONT   = 32'd1;
  localparam int unsigned DEF_V_SYNC    = 32'd3;
  localparam int unsigned DEF_V_BACK    = 32'd38;

  // Sync pins are active-high for this mode
  localparam bit DEF_SYNC_POL = 1'b1;

  // Derived totals: 1688 pixels per line, 1066 lines per frame
  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Where along an axis a coordinate sits
  typedef enum logic [1:0] {
    PHASE_VISIBLE = 2'd0,
    PHASE_FRONT   = 2'd1,
    PHASE_SYNC    = 2'd2,
    PHASE_BACK    = 2'd3
  } axis_phase_e;

  // Pure decode of a coordinate into its phase. The bounds are exclusive end
  // points of each region; comparison is done unsigned at 32 bits so a region
  // ending exactly at 4096 still compares correctly.
  function automatic axis_phase_e axis_phase(
    input coord_t      pos,
    input int unsigned visible_end,
    input int unsigned front_end,
    input int unsigned sync_end
  );
    axis_phase_e ph;
    if (32'(pos) < visible_end) begin
      ph = PHASE_VISIBLE;
    end else if (32'(pos) < front_end) begin
      ph = PHASE_FRONT;
    end else if (32'(pos) < sync_end) begin
      ph = PHASE_SYNC;
    end else begin
      ph = PHASE_BACK;
    end
    return ph;
  endfunction

endpackage : vga_pkg

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (line or frame direction). Counts 0..TOTAL-1 on each enabled
// edge, wrapping to 0. The sync and visible flags are registered from the
// next-state count so they always describe the count currently presented.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (count parks at TOTAL-1)
//   en       in   advance this axis on the current edge
//   count    out  current position, 0..TOTAL-1
//   term     out  combinational: this edge advances from TOTAL-1 back to 0
//                 (used to enable the next axis in the cascade)
//   wrap     out  registered one-cycle flag: the count just wrapped to 0
//   sync     out  registered sync level for the presented count
//   visible  out  registered: presented count is inside the visible region
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned FRONT    = DEF_H_FRONT,
  parameter int unsigned SYNC     = DEF_H_SYNC,
  parameter int unsigned BACK     = DEF_H_BACK,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               term,
  output logic               wrap,
  output logic               sync,
  output logic               visible
);

  localparam int unsigned TOTAL     = VISIBLE + FRONT + SYNC + BACK;
  localparam int unsigned FRONT_END = VISIBLE + FRONT;
  localparam int unsigned SYNC_END  = VISIBLE + FRONT + SYNC;
  localparam coord_t      LAST      = coord_t'(TOTAL - 32'd1);

  // The axis must fit the 12-bit coordinate and have somewhere to count
  if (TOTAL > COORD_RANGE) begin : g_total_too_large
    $error("vga_axis_counter: axis total exceeds the 12-bit coordinate range");
  end
  if (TOTAL < 32'd2) begin : g_total_too_small
    $error("vga_axis_counter: axis total must be at least 2");
  end

  coord_t      count_r;
  coord_t      count_nxt_s;
  logic        term_s;
  logic        wrap_r;
  logic        sync_r;
  logic        visible_r;
  axis_phase_e phase_nxt_s;

  // Terminal-advance detect: enabled while sitting on the last position
  always_comb begin
    term_s = 1'b0;
    if (en && (count_r == LAST)) begin
      term_s = 1'b1;
    end else begin
      term_s = 1'b0;
    end
  end

  // Next-state count: wrap, increment or hold
  always_comb begin
    count_nxt_s = count_r;
    if (term_s) begin
      count_nxt_s = COORD_ZERO;
    end else if (en) begin
      count_nxt_s = count_r + COORD_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Phase of the position about to be presented
  always_comb begin
    phase_nxt_s = axis_phase(count_nxt_s, VISIBLE, FRONT_END, SYNC_END);
  end

  // Count and flags, all loaded from the next-state value in the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= LAST;
      wrap_r    <= 1'b0;
      sync_r    <= ~SYNC_POL;
      visible_r <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      wrap_r    <= term_s;
      sync_r    <= (phase_nxt_s == PHASE_SYNC) ? SYNC_POL : ~SYNC_POL;
      visible_r <= (phase_nxt_s == PHASE_VISIBLE);
    end
  end

  assign count   = count_r;
  assign term    = term_s;
  assign wrap    = wrap_r;
  assign sync    = sync_r;
  assign visible = visible_r;

endmodule : vga_axis_counter

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster scan source for the oscilloscope display. Two cascaded axis counters
// produce the column/row pair with sync pins, an active-video flag, line and
// frame start pulses and a frame counter, all cycle-aligned to the presented
// coordinate so downstream decoders can gate pixels combinationally.
//
// Ports:
//   CLK            in   system clock, rising edge
//   RESET          in   asynchronous active-high reset
//   PIX_EN         in   pixel strobe; one advance per enabled edge
//   VGA_horzCoord  out  column, 0..H_TOTAL-1
//   VGA_vertCoord  out  row, 0..V_TOTAL-1
//   HSYNC          out  horizontal sync pin
//   VSYNC          out  vertical sync pin (held for whole sync lines)
//   ACTIVE         out  column and row both in the visible region
//   LINE_START     out  one-cycle pulse when the column becomes 0
//   FRAME_START    out  one-cycle pulse when the coordinates become (0,0)
//   FRAME_CNT      out  frames started since reset, 16-bit modulo
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          SYNC_POL  = DEF_SYNC_POL
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PIX_EN,
  output logic [COORD_W-1:0]     VGA_horzCoord,
  output logic [COORD_W-1:0]     VGA_vertCoord,
  output logic                   HSYNC,
  output logic                   VSYNC,
  output logic                   ACTIVE,
  output logic                   LINE_START,
  output logic                   FRAME_START,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

  coord_t     h_count_s;
  coord_t     v_count_s;
  logic       h_term_s;
  logic       v_term_s;
  logic       h_wrap_s;
  logic       v_wrap_s;
  logic       h_sync_s;
  logic       v_sync_s;
  logic       h_visible_s;
  logic       v_visible_s;
  frame_cnt_t frame_cnt_r;

  // Column counter advances on every pixel strobe
  vga_axis_counter #(
    .VISIBLE  (H_VISIBLE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .clk      (CLK),
    .rst      (RESET),
    .en       (PIX_EN),
    .count    (h_count_s),
    .term     (h_term_s),
    .wrap     (h_wrap_s),
    .sync     (h_sync_s),
    .visible  (h_visible_s)
  );

  // Row counter advances in the same edge that the column wraps, so a frame
  // boundary is exactly the row counter's own terminal advance.
  vga_axis_counter #(
    .VISIBLE  (V_VISIBLE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .clk      (CLK),
    .rst      (RESET),
    .en       (h_term_s),
    .count    (v_count_s),
    .term     (v_term_s),
    .wrap     (v_wrap_s),
    .sync     (v_sync_s),
    .visible  (v_visible_s)
  );

  // Frame counter steps in the edge that presents (0,0)
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_cnt_r <= FRAME_ZERO;
    end else if (v_term_s) begin
      frame_cnt_r <= frame_cnt_r + FRAME_ONE;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign VGA_horzCoord = h_count_s;
  assign VGA_vertCoord = v_count_s;
  assign HSYNC         = h_sync_s;
  assign VSYNC         = v_sync_s;
  // Both flags are registered; their AND has no further logic depth
  assign ACTIVE        = h_visible_s & v_visible_s;
  // The column wraps on every line start; the row wraps only on frame start
  assign LINE_START    = h_wrap_s;
  assign FRAME_START   = v_wrap_s;
  assign FRAME_CNT     = frame_cnt_r;

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share clock, reset and pixel strobe: the 1280x1024 default
// timing, and a small 16x12 raster (inverted sync polarity) that completes
// many frames in a short run. The reference model only tracks how many pixel
// advances happened since reset and derives every expected output from that
// number by plain arithmetic on the timing numbers.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Default 1280x1024@60 raster
  localparam int BHV = 1280, BHF = 48, BHS = 112, BHB = 248;
  localparam int BVV = 1024, BVF = 1,  BVS = 3,   BVB = 38;
  // Small raster: 16 pixels x 12 lines = 192 advances per frame
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 3;
  localparam int S_PERIOD = 192;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PIX_EN;

  logic [11:0] b_hc, b_vc, s_hc, s_vc;
  logic        b_hs, b_vs, b_act, b_ls, b_fs;
  logic        s_hs, s_vs, s_act, s_ls, s_fs;
  logic [15:0] b_fc, s_fc;

  int          compared   = 0;
  int          mismatched = 0;

  // Reference state: advances since reset, and whether the last edge advanced
  longint      n_adv  = 0;
  bit          adv    = 1'b0;
  longint      cyc    = 0;
  int          streak = 0;

  // Frame-period bookkeeping (small raster)
  bit          have_fs = 1'b0;
  longint      last_fs_cyc = 0;
  logic [15:0] last_fc = 16'd0;

  vga_timing_gen dut_big (
    .CLK           (CLK),
    .RESET         (RESET),
    .PIX_EN        (PIX_EN),
    .VGA_horzCoord (b_hc),
    .VGA_vertCoord (b_vc),
    .HSYNC         (b_hs),
    .VSYNC         (b_vs),
    .ACTIVE        (b_act),
    .LINE_START    (b_ls),
    .FRAME_START   (b_fs),
    .FRAME_CNT     (b_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
    .SYNC_POL  (1'b0)
  ) dut_small (
    .CLK           (CLK),
    .RESET         (RESET),
    .PIX_EN        (PIX_EN),
    .VGA_horzCoord (s_hc),
    .VGA_vertCoord (s_vc),
    .HSYNC         (s_hs),
    .VSYNC         (s_vs),
    .ACTIVE        (s_act),
    .LINE_START    (s_ls),
    .FRAME_START   (s_fs),
    .FRAME_CNT     (s_fc)
  );

  always #5 CLK = ~CLK;

  function automatic logic [44:0] pk(input int hc, input int vc, input bit hs, input bit vs,
                                     input bit act, input bit ls, input bit fs, input int fc);
    return {12'(hc), 12'(vc), hs, vs, act, ls, fs, 16'(fc)};
  endfunction

  function automatic string fmt(input logic [44:0] v);
    return $sformatf("h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b cnt=%0d",
                     v[44:33], v[32:21], v[20], v[19], v[18], v[17], v[16], v[15:0]);
  endfunction

  task automatic chk_vec(input string name, input logic [44:0] got, input logic [44:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic chk_num(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Expected outputs after n_adv advances, from the raster geometry alone
  function automatic logic [44:0] model(input int hv, input int hf, input int hsw, input int hbp,
                                        input int vv, input int vf, input int vsw, input int vbp,
                                        input bit pol);
    int     ht, vt, col, row, fc;
    longint per, p;
    bit     e_hs, e_vs, e_act, e_ls, e_fs;
    ht  = hv + hf + hsw + hbp;
    vt  = vv + vf + vsw + vbp;
    per = longint'(ht) * longint'(vt);
    if (n_adv == 0) begin
      col = ht - 1; row = vt - 1; fc = 0; p = -1;
    end else begin
      p   = (n_adv - 1) % per;
      col = int'(p % ht);
      row = int'(p / ht);
      fc  = int'(((n_adv - 1) / per + 1) % 65536);
    end
    e_ls  = adv && (col == 0);
    e_fs  = adv && (p == 0);
    e_hs  = (col >= hv + hf && col < hv + hf + hsw) ? pol : !pol;
    e_vs  = (row >= vv + vf && row < vv + vf + vsw) ? pol : !pol;
    e_act = (col < hv) && (row < vv);
    return pk(col, row, e_hs, e_vs, e_act, e_ls, e_fs, fc);
  endfunction

  // Reference update on the active edge
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET) begin
      n_adv <= 0; adv <= 1'b0; streak <= 0;
    end else if (PIX_EN) begin
      n_adv <= n_adv + 1; adv <= 1'b1; streak <= streak + 1;
    end else begin
      adv <= 1'b0; streak <= 0;
    end
  end

  // Per-cycle compare on the falling edge, plus small-raster frame period
  always @(negedge CLK) begin
    chk_vec("big_model", {b_hc, b_vc, b_hs, b_vs, b_act, b_ls, b_fs, b_fc},
            model(BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, 1'b1));
    chk_vec("small_model", {s_hc, s_vc, s_hs, s_vs, s_act, s_ls, s_fs, s_fc},
            model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0));
    if (s_fs === 1'b1) begin
      if (have_fs && streak >= S_PERIOD) begin
        chk_num("frame_period", 64'(cyc - last_fs_cyc), 64'd192);
        chk_num("frame_cnt_step", 64'(s_fc), 64'(16'(last_fc + 16'd1)));
      end
      have_fs     = 1'b1;
      last_fs_cyc = cyc;
      last_fc     = s_fc;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [44:0] big_now();
    return {b_hc, b_vc, b_hs, b_vs, b_act, b_ls, b_fs, b_fc};
  endfunction

  function automatic logic [44:0] small_now();
    return {s_hc, s_vc, s_hs, s_vs, s_act, s_ls, s_fs, s_fc};
  endfunction

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET  = 1'b1;
    PIX_EN = 1'b0;
    repeat (3) tick();
    chk_vec("big_reset",   big_now(),   pk(1687, 1065, 0, 0, 0, 0, 0, 0));
    chk_vec("small_reset", small_now(), pk(15, 11, 1, 1, 0, 0, 0, 0));

    // Release with the strobe already high: first edge lands on (0,0)
    RESET  = 1'b0;
    PIX_EN = 1'b1;
    tick();
    chk_vec("big_first",   big_now(),   pk(0, 0, 0, 0, 1, 1, 1, 1));
    chk_vec("small_first", small_now(), pk(0, 0, 1, 1, 1, 1, 1, 1));

    // Walk the first line across the visible/blank and sync boundaries
    repeat (1279) tick();
    chk_vec("col1279_active", big_now(), pk(1279, 0, 0, 0, 1, 0, 0, 1));
    tick();
    chk_vec("col1280_blank",  big_now(), pk(1280, 0, 0, 0, 0, 0, 0, 1));
    repeat (47) tick();
    chk_vec("col1327_nosync", big_now(), pk(1327, 0, 0, 0, 0, 0, 0, 1));
    tick();
    chk_vec("col1328_sync",   big_now(), pk(1328, 0, 1, 0, 0, 0, 0, 1));
    repeat (111) tick();
    chk_vec("col1439_sync",   big_now(), pk(1439, 0, 1, 0, 0, 0, 0, 1));
    tick();
    chk_vec("col1440_nosync", big_now(), pk(1440, 0, 0, 0, 0, 0, 0, 1));

    // Line wrap from (1687,5) to (0,6)
    repeat (8687) tick();
    chk_vec("end_of_row5",  big_now(), pk(1687, 5, 0, 0, 0, 0, 0, 1));
    tick();
    chk_vec("wrap_to_row6", big_now(), pk(0, 6, 0, 0, 1, 1, 0, 1));

    // Strobe pattern 1,0,0,1 across a line wrap
    repeat (1687) tick();
    chk_vec("end_of_row6", big_now(), pk(1687, 6, 0, 0, 0, 0, 0, 1));
    PIX_EN = 1'b1; tick();
    chk_vec("gate_adv1",  big_now(), pk(0, 7, 0, 0, 1, 1, 0, 1));
    PIX_EN = 1'b0; tick();
    chk_vec("gate_hold1", big_now(), pk(0, 7, 0, 0, 1, 0, 0, 1));
    tick();
    chk_vec("gate_hold2", big_now(), pk(0, 7, 0, 0, 1, 0, 0, 1));
    PIX_EN = 1'b1; tick();
    chk_vec("gate_adv2",  big_now(), pk(1, 7, 0, 0, 1, 0, 0, 1));

    // Random strobe gating
    repeat (3000) begin
      PIX_EN = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Mid-frame asynchronous reset on the small raster
    PIX_EN = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ((n_adv % S_PERIOD) >= 50 && (n_adv % S_PERIOD) <= 150) break;
      tick();
    end
    RESET = 1'b1;
    #1;
    chk_vec("big_async_reset",   big_now(),   pk(1687, 1065, 0, 0, 0, 0, 0, 0));
    chk_vec("small_async_reset", small_now(), pk(15, 11, 1, 1, 0, 0, 0, 0));
    PIX_EN = 1'b0;
    repeat (2) tick();
    chk_vec("big_reset_held", big_now(), pk(1687, 1065, 0, 0, 0, 0, 0, 0));
    RESET  = 1'b0;
    PIX_EN = 1'b1;
    tick();
    chk_vec("big_resume",   big_now(),   pk(0, 0, 0, 0, 1, 1, 1, 1));
    chk_vec("small_resume", small_now(), pk(0, 0, 1, 1, 1, 1, 1, 1));

    // More random gating, then a continuous stretch of several small frames
    repeat (2000) begin
      PIX_EN = ($urandom_range(0, 1) != 0);
      tick();
    end
    PIX_EN = 1'b1;
    repeat (600) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_vga_timing_gen
